id_ex_reg: RTL

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg_if.sv | 61 ++++++
 rtl/id_ex_reg.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/id_ex_reg_if.sv
// Decode-to-execute pipeline bundle: decode-side fields (D) and the
// registered execute-side fields (E) plus the EX-stage operand muxes.
interface id_ex_reg_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int OP_WIDTH       = 2,
   parameter int REG_ADDR_WIDTH = 5
);
   // Decode-stage slot
   logic                      validD;
   logic [DATA_WIDTH-1:0]     rd1D;
   logic [DATA_WIDTH-1:0]     rd2D;
   logic [DATA_WIDTH-1:0]     signImmD;
   logic [OP_WIDTH-1:0]       aluFuncD;
   logic                      aluSrcD;
   logic                      regDstD;
   logic                      regWriteD;
   logic                      memWriteD;
   logic                      memToRegD;
   logic [REG_ADDR_WIDTH-1:0] rsD;
   logic [REG_ADDR_WIDTH-1:0] rtD;
   logic [REG_ADDR_WIDTH-1:0] rdD;

   // Execute-stage registers
   logic                      validE;
   logic [DATA_WIDTH-1:0]     rd1E;
   logic [DATA_WIDTH-1:0]     rd2E;
   logic [DATA_WIDTH-1:0]     signImmE;
   logic [OP_WIDTH-1:0]       aluFuncE;
   logic                      aluSrcE;
   logic                      regDstE;
   logic                      regWriteE;
   logic                      memWriteE;
   logic                      memToRegE;
   logic [REG_ADDR_WIDTH-1:0] rsE;
   logic [REG_ADDR_WIDTH-1:0] rtE;
   logic [REG_ADDR_WIDTH-1:0] rdE;

   // Execute-stage combinational selections
   logic [DATA_WIDTH-1:0]     srcBE;
   logic [REG_ADDR_WIDTH-1:0] writeRegE;

   // Decode side: drives the D slot, observes the E stage
   modport master (
      output validD, rd1D, rd2D, signImmD, aluFuncD,
             aluSrcD, regDstD, regWriteD, memWriteD, memToRegD,
             rsD, rtD, rdD,
      input  validE, rd1E, rd2E, signImmE, aluFuncE,
             aluSrcE, regDstE, regWriteE, memWriteE, memToRegE,
             rsE, rtE, rdE, srcBE, writeRegE
   );

   // Pipeline register side: samples the D slot, produces the E stage
   modport slave (
      input  validD, rd1D, rd2D, signImmD, aluFuncD,
             aluSrcD, regDstD, regWriteD, memWriteD, memToRegD,
             rsD, rtD, rdD,
      output validE, rd1E, rd2E, signImmE, aluFuncE,
             aluSrcE, regDstE, regWriteE, memWriteE, memToRegE,
             rsE, rtE, rdE, srcBE, writeRegE
   );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush/stall control, side-effect gating for
// non-valid slots, EX-stage operand/destination muxes and a saturating
// bubble counter.
module id_ex_reg #(
   parameter int DATA_WIDTH     = 32,
   parameter int OP_WIDTH       = 2,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stallE,
   input  logic        flushE,
   id_ex_reg_if.slave  bus,
   output logic [15:0] bubbleCnt
);

   localparam logic [15:0] BUBBLE_MAX = 16'hFFFF;

   logic                      valid_q,     valid_d;
   logic [DATA_WIDTH-1:0]     rd1_q,       rd1_d;
   logic [DATA_WIDTH-1:0]     rd2_q,       rd2_d;
   logic [DATA_WIDTH-1:0]     sign_imm_q,  sign_imm_d;
   logic [OP_WIDTH-1:0]       alu_func_q,  alu_func_d;
   logic                      alu_src_q,   alu_src_d;
   logic                      reg_dst_q,   reg_dst_d;
   logic                      reg_write_q, reg_write_d;
   logic                      mem_write_q, mem_write_d;
   logic                      mem_to_reg_q, mem_to_reg_d;
   logic [REG_ADDR_WIDTH-1:0] rs_q,        rs_d;
   logic [REG_ADDR_WIDTH-1:0] rt_q,        rt_d;
   logic [REG_ADDR_WIDTH-1:0] rd_q,        rd_d;
   logic [15:0]               bubble_cnt_q, bubble_cnt_d;

   logic bubble_in;

   // Next-state selection: flush beats stall beats normal load
   always_comb begin
      valid_d      = valid_q;
      rd1_d        = rd1_q;
      rd2_d        = rd2_q;
      sign_imm_d   = sign_imm_q;
      alu_func_d   = alu_func_q;
      alu_src_d    = alu_src_q;
      reg_dst_d    = reg_dst_q;
      reg_write_d  = reg_write_q;
      mem_write_d  = mem_write_q;
      mem_to_reg_d = mem_to_reg_q;
      rs_d         = rs_q;
      rt_d         = rt_q;
      rd_d         = rd_q;

      if (flushE) begin
         valid_d      = 1'b0;
         rd1_d        = '0;
         rd2_d        = '0;
         sign_imm_d   = '0;
         alu_func_d   = '0;
         alu_src_d    = 1'b0;
         reg_dst_d    = 1'b0;
         reg_write_d  = 1'b0;
         mem_write_d  = 1'b0;
         mem_to_reg_d = 1'b0;
         rs_d         = '0;
         rt_d         = '0;
         rd_d         = '0;
      end else if (!stallE) begin
         valid_d      = bus.validD;
         rd1_d        = bus.rd1D;
         rd2_d        = bus.rd2D;
         sign_imm_d   = bus.signImmD;
         alu_func_d   = bus.aluFuncD;
         alu_src_d    = bus.aluSrcD;
         reg_dst_d    = bus.regDstD;
         // A non-valid slot must not write the register file or memory
         reg_write_d  = bus.regWriteD & bus.validD;
         mem_write_d  = bus.memWriteD & bus.validD;
         mem_to_reg_d = bus.memToRegD;
         rs_d         = bus.rsD;
         rt_d         = bus.rtD;
         rd_d         = bus.rdD;
      end
   end

   // Bubble accounting: a flush, or an unstalled load of a non-valid slot
   always_comb begin
      bubble_in    = flushE | (~stallE & ~bus.validD);
      bubble_cnt_d = bubble_cnt_q;
      if (bubble_in && (bubble_cnt_q != BUBBLE_MAX)) begin
         bubble_cnt_d = bubble_cnt_q + 16'd1;
      end
   end

   // EX-stage state registers with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         rd1_q        <= '0;
         rd2_q        <= '0;
         sign_imm_q   <= '0;
         alu_func_q   <= '0;
         alu_src_q    <= 1'b0;
         reg_dst_q    <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         rs_q         <= '0;
         rt_q         <= '0;
         rd_q         <= '0;
         bubble_cnt_q <= '0;
      end else begin
         valid_q      <= valid_d;
         rd1_q        <= rd1_d;
         rd2_q        <= rd2_d;
         sign_imm_q   <= sign_imm_d;
         alu_func_q   <= alu_func_d;
         alu_src_q    <= alu_src_d;
         reg_dst_q    <= reg_dst_d;
         reg_write_q  <= reg_write_d;
         mem_write_q  <= mem_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         rs_q         <= rs_d;
         rt_q         <= rt_d;
         rd_q         <= rd_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   // Register outputs
   assign bus.validE    = valid_q;
   assign bus.rd1E      = rd1_q;
   assign bus.rd2E      = rd2_q;
   assign bus.signImmE  = sign_imm_q;
   assign bus.aluFuncE  = alu_func_q;
   assign bus.aluSrcE   = alu_src_q;
   assign bus.regDstE   = reg_dst_q;
   assign bus.regWriteE = reg_write_q;
   assign bus.memWriteE = mem_write_q;
   assign bus.memToRegE = mem_to_reg_q;
   assign bus.rsE       = rs_q;
   assign bus.rtE       = rt_q;
   assign bus.rdE       = rd_q;
   assign bubbleCnt     = bubble_cnt_q;

   // EX-stage muxes driven only from registered state
   assign bus.srcBE     = alu_src_q ? sign_imm_q : rd2_q;
   assign bus.writeRegE = reg_dst_q ? rd_q : rt_q;

endmodule
